image_uart_dumper: RTL and testbench



---
 rtl/image_uart_dumper.sv | 158 +++++++++++++++
 tb/tb_image_uart_dumper.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_uart_dumper.sv
// Walks the image memory in ascending address order and transmits every pixel
// as one 8N1 UART frame, LSB first, idle high.
`timescale 1ns/1ps
module image_uart_dumper #(
  parameter int CLKS_PER_BIT = 434,
  parameter int N_PIXELS     = 65536,
  parameter int ADDR_W       = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_PIXELS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              baud_end;

  assign baud_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          state_d = S_FETCH;
          addr_d  = '0;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      // Memory registers the address this cycle; data is valid in LOAD.
      S_FETCH: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end

      S_LOAD: begin
        shift_d = mem_data;
        tx_d    = 1'b0;
        state_d = S_START;
        cnt_d   = '0;
      end

      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // tx is loaded with the next bit at the same edge the register shifts,
      // so the line stays a pure flop output.
      S_DATA: begin
        if (baud_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          cnt_d = '0;
          if (addr_q == ADDR_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_addr = addr_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_image_uart_dumper.sv
// Directed bench for image_uart_dumper: three instances with different
// baud/pixel-count parameters, each fed by a synchronous-read memory model.
`timescale 1ns/1ps
module tb_image_uart_dumper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [17:0] addr_a, addr_b, addr_c;
  logic [7:0]  md_a, md_b, md_c;
  logic        tx_a, tx_b, tx_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem_b [4];

  always @(posedge clk) md_a <= (addr_a == 18'd0) ? 8'hA5 : 8'h00;
  always @(posedge clk) md_b <= mem_b[addr_b[1:0]];
  always @(posedge clk) begin
    case (addr_c)
      18'd0:   md_c <= 8'h55;
      18'd1:   md_c <= 8'h0F;
      18'd2:   md_c <= 8'hC3;
      default: md_c <= 8'h00;
    endcase
  end

  image_uart_dumper #(.CLKS_PER_BIT(4), .N_PIXELS(1), .ADDR_W(18)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mem_addr(addr_a),
    .mem_data(md_a), .tx(tx_a), .busy(busy_a), .done(done_a));

  image_uart_dumper #(.CLKS_PER_BIT(4), .N_PIXELS(4), .ADDR_W(18)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mem_addr(addr_b),
    .mem_data(md_b), .tx(tx_b), .busy(busy_b), .done(done_b));

  image_uart_dumper #(.CLKS_PER_BIT(434), .N_PIXELS(3), .ADDR_W(18)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .mem_addr(addr_c),
    .mem_data(md_c), .tx(tx_c), .busy(busy_c), .done(done_c));

  // Expected line level t cycles after the start-sampling edge.
  function automatic logic exp_tx(int t, int c, int n, logic [31:0] bytes);
    int l, k, p;
    l = 10 * c + 2;
    if (t < 2) return 1'b1;
    k = (t - 2) / l;
    p = (t - 2) % l;
    if (k >= n) return 1'b1;
    if (p < c) return 1'b0;
    if (p < 9 * c) return bytes[8 * k + (p - c) / c];
    return 1'b1;
  endfunction

  function automatic int exp_addr(int t, int c, int n);
    int a;
    a = t / (10 * c + 2);
    if (a > n - 1) a = n - 1;
    return a;
  endfunction

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_tx_a got=%b exp=1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
    checks++; if (tx_b !== 1'b1) begin errors++; $display("FAIL reset_tx_b got=%b exp=1", tx_b); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b got=%b exp=0", busy_b); end
    checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL reset_done_b got=%b exp=0", done_b); end
    checks++; if (addr_b !== 18'd0) begin errors++; $display("FAIL reset_addr_b got=%0d exp=0", addr_b); end
    checks++; if (tx_c !== 1'b1) begin errors++; $display("FAIL reset_tx_c got=%b exp=1", tx_c); end
    checks++; if (done_c !== 1'b0) begin errors++; $display("FAIL reset_done_c got=%b exp=0", done_c); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_pixel();
    int ndone;
    ndone = 0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int t = 0; t <= 44; t++) begin
      if (t > 0) @(negedge clk);
      if (done_a === 1'b1) ndone++;
      checks++;
      if (tx_a !== exp_tx(t, 4, 1, 32'h0000_00A5)) begin
        errors++; $display("FAIL single_tx t=%0d got=%b exp=%b", t, tx_a, exp_tx(t, 4, 1, 32'h0000_00A5));
      end
      checks++;
      if (busy_a !== (t < 42)) begin
        errors++; $display("FAIL single_busy t=%0d got=%b exp=%b", t, busy_a, (t < 42));
      end
      checks++;
      if (done_a !== (t == 42)) begin
        errors++; $display("FAIL single_done t=%0d got=%b exp=%b", t, done_a, (t == 42));
      end
      checks++;
      if (addr_a !== 18'd0) begin
        errors++; $display("FAIL single_addr t=%0d got=%0d exp=0", t, addr_a);
      end
    end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL single_done_count got=%0d exp=1", ndone); end
  endtask

  // One full 4-pixel dump on dut_b, checked cycle by cycle and decoded by a
  // mid-bit sampling receiver. pre: start already accepted; disturb: extra
  // starts while busy; chain: start held high across the done cycle.
  task automatic run_multi(input bit pre, input bit disturb, input bit chain, input string tag);
    logic [7:0] rx [4];
    int         edge_t [4];
    int         nrx, ndone, t0, d;
    bit         rx_on;
    logic       prev;
    logic [7:0] sh;
    logic [31:0] bytes;
    bytes = 32'h8001_FF00;
    nrx = 0; ndone = 0; t0 = 0; rx_on = 0; prev = 1'b1; sh = '0;
    for (int k = 0; k < 4; k++) begin rx[k] = 8'h00; edge_t[k] = -1; end
    if (!pre) begin
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
    end
    for (int t = 0; t <= 168; t++) begin
      if (t > 0) @(negedge clk);
      if (done_b === 1'b1) ndone++;
      checks++;
      if (tx_b !== exp_tx(t, 4, 4, bytes)) begin
        errors++; $display("FAIL %s_tx t=%0d got=%b exp=%b", tag, t, tx_b, exp_tx(t, 4, 4, bytes));
      end
      checks++;
      if (busy_b !== (t < 168)) begin
        errors++; $display("FAIL %s_busy t=%0d got=%b exp=%b", tag, t, busy_b, (t < 168));
      end
      checks++;
      if (done_b !== (t == 168)) begin
        errors++; $display("FAIL %s_done t=%0d got=%b exp=%b", tag, t, done_b, (t == 168));
      end
      checks++;
      if (addr_b !== 18'(exp_addr(t, 4, 4))) begin
        errors++; $display("FAIL %s_addr t=%0d got=%0d exp=%0d", tag, t, addr_b, exp_addr(t, 4, 4));
      end
      if (!rx_on && prev === 1'b1 && tx_b === 1'b0) begin
        rx_on = 1; t0 = t;
        if (nrx < 4) edge_t[nrx] = t;
      end else if (rx_on) begin
        d = t - t0;
        if (d >= 6 && d <= 34 && ((d - 6) % 4) == 0) sh = {tx_b, sh[7:1]};
        if (d == 38) begin
          if (nrx < 4) rx[nrx] = sh;
          nrx++;
          rx_on = 0;
        end
      end
      prev = tx_b;
      start_b = (disturb && (t == 49 || t == 99)) || (chain && (t == 167 || t == 168));
    end
    if (chain) begin
      @(negedge clk);
      start_b = 1'b0;
    end
    checks++;
    if (nrx != 4) begin errors++; $display("FAIL %s_rx_count got=%0d exp=4", tag, nrx); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx[k] !== bytes[8*k +: 8]) begin
        errors++; $display("FAIL %s_rx_byte%0d got=%h exp=%h", tag, k, rx[k], bytes[8*k +: 8]);
      end
      checks++;
      if (edge_t[k] != 2 + 42 * k) begin
        errors++; $display("FAIL %s_start_edge%0d got=%0d exp=%0d", tag, k, edge_t[k], 2 + 42 * k);
      end
    end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL %s_done_count got=%0d exp=1", tag, ndone); end
  endtask

  task automatic test_multi_pixel();
    run_multi(1'b0, 1'b0, 1'b0, "multi");
  endtask

  task automatic test_start_while_busy();
    repeat (3) @(negedge clk);
    run_multi(1'b0, 1'b1, 1'b0, "busy_start");
  endtask

  task automatic test_reset_mid_frame();
    repeat (3) @(negedge clk);
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_b !== 1'b0) begin errors++; $display("FAIL rst_pre_startbit_tx got=%b exp=0", tx_b); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (tx_b !== 1'b1) begin errors++; $display("FAIL rst_startbit_tx got=%b exp=1", tx_b); end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);

    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    repeat (61) @(negedge clk);
    checks++;
    if (addr_b !== 18'd1) begin errors++; $display("FAIL rst_pre_addr got=%0d exp=1", addr_b); end
    checks++;
    if (busy_b !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got=%b exp=1", busy_b); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (tx_b !== 1'b1) begin errors++; $display("FAIL rst_mid_tx got=%b exp=1", tx_b); end
    checks++;
    if (busy_b !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy_b); end
    checks++;
    if (addr_b !== 18'd0) begin errors++; $display("FAIL rst_mid_addr got=%0d exp=0", addr_b); end
    checks++;
    if (done_b !== 1'b0) begin errors++; $display("FAIL rst_mid_done got=%b exp=0", done_b); end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    run_multi(1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    repeat (3) @(negedge clk);
    run_multi(1'b0, 1'b0, 1'b1, "b2b_first");
    run_multi(1'b1, 1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_default_smoke();
    int   edges [10];
    int   ne, bad, done_t, ndone;
    logic prev;
    logic [31:0] bytes;
    bytes = 32'h00C3_0F55;
    ne = 0; bad = 0; done_t = -1; ndone = 0; prev = 1'b1;
    for (int i = 0; i < 10; i++) edges[i] = -1;
    @(negedge clk); start_c = 1'b1;
    @(negedge clk); start_c = 1'b0;
    for (int t = 0; t <= 13028; t++) begin
      if (t > 0) @(negedge clk);
      if (tx_c !== exp_tx(t, 434, 3, bytes)) bad++;
      if (busy_c !== (t < 13026)) bad++;
      if (addr_c !== 18'(exp_addr(t, 434, 3))) bad++;
      if (done_c === 1'b1) begin ndone++; done_t = t; end
      if (tx_c !== prev) begin
        if (ne < 10) edges[ne] = t;
        ne++;
      end
      prev = tx_c;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL smoke_stream mismatching_samples=%0d exp=0", bad); end
    checks++;
    if (edges[0] != 2) begin errors++; $display("FAIL smoke_first_edge got=%0d exp=2", edges[0]); end
    for (int i = 1; i < 10; i++) begin
      checks++;
      if (edges[i] - edges[i-1] != 434) begin
        errors++; $display("FAIL smoke_bit_len%0d got=%0d exp=434", i, edges[i] - edges[i-1]);
      end
    end
    checks++;
    if (done_t != 13026) begin errors++; $display("FAIL smoke_done_time got=%0d exp=13026", done_t); end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL smoke_done_count got=%0d exp=1", ndone); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    mem_b[0] = 8'h00;
    mem_b[1] = 8'hFF;
    mem_b[2] = 8'h01;
    mem_b[3] = 8'h80;
    test_reset();
    test_single_pixel();
    test_multi_pixel();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    test_default_smoke();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
